// File: rtl/alu_arbiter_if.sv
// Bus between the two ALU requesters, the shared ALU and the alu_arbiter.
// The slave modport is the arbiter side; the master modport is the requester/ALU side.
interface alu_arbiter_if #(
  parameter int WIDTH = 5,
  parameter int OPW   = 3
);
  // reqN is the valid of a transaction; it stays high with stable intent until
  // the one-cycle ackN completion pulse, which doubles as ready/done.
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic [OPW-1:0]   op0;
  logic [OPW-1:0]   op1;
  logic             ack0;
  logic             ack1;
  logic [WIDTH-1:0] res0;
  logic [WIDTH-1:0] res1;
  logic             flag0;
  logic             flag1;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OPW-1:0]   alu_op;
  logic             alu_start;
  logic [WIDTH-1:0] alu_result;
  logic             alu_flag;
  logic             busy;
  logic             grant_id;
  logic [1:0]       dbg_state;

  modport slave (
    input  req0, req1, a0, b0, a1, b1, op0, op1, alu_result, alu_flag,
    output ack0, ack1, res0, res1, flag0, flag1, alu_a, alu_b, alu_op,
           alu_start, busy, grant_id, dbg_state
  );

  modport master (
    output req0, req1, a0, b0, a1, b1, op0, op1, alu_result, alu_flag,
    input  ack0, ack1, res0, res1, flag0, flag1, alu_a, alu_b, alu_op,
           alu_start, busy, grant_id, dbg_state
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared fixed-latency ALU.
// Define ALU_ARB_RR_EN for round-robin selection; otherwise req0 has fixed priority.
module alu_arbiter #(
  parameter int WIDTH   = 5,
  parameter int OPW     = 3,
  parameter int ALU_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  alu_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_cnt;
  logic             r_grant;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [OPW-1:0]   r_alu_op;
  logic [WIDTH-1:0] r_res0;
  logic [WIDTH-1:0] r_res1;
  logic             r_flag0;
  logic             r_flag1;
  logic             w_any;
  logic             w_sel;
  logic             w_start;
  logic             w_busy;
  logic             w_ack0;
  logic             w_ack1;

  assign w_any = bus.req0 | bus.req1;

`ifdef ALU_ARB_RR_EN
  // r_prio names the requester that wins a tie: the one not served last.
  logic r_prio;

  always_ff @(posedge clk) begin
    if (!reset)                r_prio <= 1'b0;
    else if (r_state == RESP)  r_prio <= ~r_grant;
  end

  always_comb begin
    w_sel = bus.req1 & ~bus.req0;
    if (bus.req0 && bus.req1) w_sel = r_prio;
  end
`else
  assign w_sel = ~bus.req0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT:    if (r_cnt == 4'd0) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_start = (r_state == ISSUE);
    w_busy  = (r_state != IDLE);
    w_ack0  = (r_state == RESP) && !r_grant;
    w_ack1  = (r_state == RESP) &&  r_grant;
  end

  // Operands are frozen at grant so requester changes cannot reach the ALU.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_grant  <= 1'b0;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_op <= '0;
      r_res0   <= '0;
      r_res1   <= '0;
      r_flag0  <= 1'b0;
      r_flag1  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          r_grant  <= w_sel;
          r_alu_a  <= w_sel ? bus.a1  : bus.a0;
          r_alu_b  <= w_sel ? bus.b1  : bus.b0;
          r_alu_op <= w_sel ? bus.op1 : bus.op0;
        end
        ISSUE: r_cnt <= LAT_M1;
        WAIT: begin
          if (r_cnt == 4'd0) begin
            if (r_grant) begin
              r_res1  <= bus.alu_result;
              r_flag1 <= bus.alu_flag;
            end else begin
              r_res0  <= bus.alu_result;
              r_flag0 <= bus.alu_flag;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ack0      = w_ack0;
  assign bus.ack1      = w_ack1;
  assign bus.res0      = r_res0;
  assign bus.res1      = r_res1;
  assign bus.flag0     = r_flag0;
  assign bus.flag1     = r_flag1;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_op    = r_alu_op;
  assign bus.alu_start = w_start;
  assign bus.busy      = w_busy;
  assign bus.grant_id  = r_grant;
  assign bus.dbg_state = r_state;
endmodule
